// File: rtl/cofactor_row_sequencer.sv
// Row sequencer feeding the cofactor control unit.
// Holds one stabilizer tableau (num_qubit rows of literals plus a phase vector).
// A pass streams the rows out one per cycle, waits P_GAP idle cycles, then strobes valid_P.
// The num_qubit result rows that come back overwrite the buffer, so the next gate can
// restart from it without a reload.
module cofactor_row_sequencer #(
  parameter int num_qubit = 3,
  parameter int P_GAP     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_load,
  input  logic [2*num_qubit-1:0]      literals_load,
  input  logic [(1<<num_qubit)-1:0]   phase_load,
  input  logic                        start,
  output logic                        valid_in,
  output logic [2*num_qubit-1:0]      literals_in,
  output logic [(1<<num_qubit)-1:0]   phase_in,
  output logic                        valid_P,
  input  logic                        valid_out,
  input  logic [2*num_qubit-1:0]      literals_out,
  input  logic [(1<<num_qubit)-1:0]   phase_out,
  output logic                        full,
  output logic                        busy,
  output logic                        done,
  output logic                        load_err
);

  localparam int LW = 2 * num_qubit;
  localparam int PHW = 1 << num_qubit;
  localparam int PW = $clog2(num_qubit + 1);
  localparam int IW = (num_qubit > 1) ? $clog2(num_qubit) : 1;

  localparam logic [PW-1:0] LAST_ROW = PW'(num_qubit - 1);
  localparam logic [PW-1:0] ROWS     = PW'(num_qubit);
  localparam logic [3:0]    GAP_LAST = 4'((P_GAP > 0) ? (P_GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FULL,
    S_STREAM,
    S_GAP,
    S_PSTB,
    S_WAIT
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [3:0]        gap_q;
  logic              valid_in_q;
  logic [LW-1:0]     literals_in_q;
  logic [PHW-1:0]    phase_in_q;
  logic              valid_p_q;
  logic              full_q;
  logic              busy_q;
  logic              done_q;
  logic              load_err_q;

  // Tableau storage; contents are don't-care after reset, so no reset is applied.
  logic [LW-1:0]     lit_buf [num_qubit];
  logic [PHW-1:0]    ph_buf  [num_qubit];

  logic [IW-1:0]     row_idx_d;
  logic              load_we_d;
  logic              cap_we_d;

  // Buffer index and write enables derived from the current state.
  always_comb begin
    row_idx_d = ptr_q[IW-1:0];
    load_we_d = (state_q == S_LOAD) && valid_load;
    cap_we_d  = (state_q == S_WAIT) && valid_out;
  end

  // Row buffer: written by host loads in LOAD and by result captures in WAIT.
  always_ff @(posedge clk) begin
    if (load_we_d) begin
      lit_buf[row_idx_d] <= literals_load;
      ph_buf[row_idx_d]  <= phase_load;
    end else if (cap_we_d) begin
      lit_buf[row_idx_d] <= literals_out;
      ph_buf[row_idx_d]  <= phase_out;
    end
  end

  // Pass sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      ptr_q         <= '0;
      gap_q         <= '0;
      valid_in_q    <= 1'b0;
      literals_in_q <= '0;
      phase_in_q    <= '0;
      valid_p_q     <= 1'b0;
      full_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (valid_load && (state_q != S_LOAD)) begin
        load_err_q <= 1'b1;
      end
      case (state_q)
        S_LOAD: begin
          if (start) begin
            load_err_q <= 1'b1;
          end
          if (valid_load) begin
            if (ptr_q == LAST_ROW) begin
              state_q <= S_FULL;
              ptr_q   <= '0;
              full_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + PW'(1);
            end
          end
        end
        S_FULL: begin
          // Row 0 is presented straight from the accepting edge so the stream
          // starts one cycle after start is sampled.
          if (start) begin
            state_q       <= S_STREAM;
            full_q        <= 1'b0;
            busy_q        <= 1'b1;
            valid_in_q    <= 1'b1;
            literals_in_q <= lit_buf[0];
            phase_in_q    <= ph_buf[0];
            ptr_q         <= PW'(1);
          end
        end
        S_STREAM: begin
          if (ptr_q == ROWS) begin
            valid_in_q    <= 1'b0;
            literals_in_q <= '0;
            phase_in_q    <= '0;
            ptr_q         <= '0;
            gap_q         <= '0;
            if (P_GAP > 0) begin
              state_q <= S_GAP;
            end else begin
              state_q   <= S_PSTB;
              valid_p_q <= 1'b1;
            end
          end else begin
            literals_in_q <= lit_buf[row_idx_d];
            phase_in_q    <= ph_buf[row_idx_d];
            ptr_q         <= ptr_q + PW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q   <= S_PSTB;
            valid_p_q <= 1'b1;
            gap_q     <= '0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        S_PSTB: begin
          valid_p_q <= 1'b0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (valid_out) begin
            if (ptr_q == LAST_ROW) begin
              state_q <= S_FULL;
              ptr_q   <= '0;
              full_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + PW'(1);
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Output ports are the registered values.
  always_comb begin
    valid_in    = valid_in_q;
    literals_in = literals_in_q;
    phase_in    = phase_in_q;
    valid_P     = valid_p_q;
    full        = full_q;
    busy        = busy_q;
    done        = done_q;
    load_err    = load_err_q;
  end

endmodule
